block_nest_checker: RTL

BLOCK_NEST_CHECKER -- requirements
Module: block_nest_checker

---
 rtl/block_nest_checker.sv | 119 +++++++++++
 1 files changed

// File: rtl/block_nest_checker.sv
// Streaming checker for begin/end keyword nesting in an ASCII character stream.
// A per-word FSM spots the keywords and the depth counter commits on the closing delimiter.
module block_nest_checker #(
    parameter int DEPTH_W   = 8,
    parameter int MAX_DEPTH = 255,
    parameter bit CASE_INS  = 1'b1,
    parameter bit WS_DELIM  = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               result,
    output logic [DEPTH_W-1:0] depth,
    output logic               err_underflow,
    output logic               err_overflow
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_B1   = 4'd1;
    localparam logic [3:0] S_B2   = 4'd2;
    localparam logic [3:0] S_B3   = 4'd3;
    localparam logic [3:0] S_B4   = 4'd4;
    localparam logic [3:0] S_BEG  = 4'd5;
    localparam logic [3:0] S_E1   = 4'd6;
    localparam logic [3:0] S_E2   = 4'd7;
    localparam logic [3:0] S_END  = 4'd8;
    localparam logic [3:0] S_JUNK = 4'd9;

    localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);

    logic [3:0]         state, state_nxt;
    logic [DEPTH_W-1:0] depth_nxt;
    logic               uf_nxt, of_nxt;
    logic               delim;
    logic signed [DEPTH_W:0] pend, balance;

    function automatic logic is_delim(input logic [7:0] c);
        return (c == 8'h20) ||
               (WS_DELIM && ((c == 8'h09) || (c == 8'h0A) || (c == 8'h0D)));
    endfunction

    // Clearing bit 5 of a lowercase letter gives its uppercase form.
    function automatic logic is_letter(input logic [7:0] c, input logic [7:0] lc);
        return (c == lc) || (CASE_INS && (c == (lc & 8'hDF)));
    endfunction

    // Bounded depth steps: the caller checks the limit, so these never wrap.
    function automatic logic [DEPTH_W-1:0] depth_inc(input logic [DEPTH_W-1:0] d);
        return (d < MAX_D) ? d + 1'b1 : d;
    endfunction

    function automatic logic [DEPTH_W-1:0] depth_dec(input logic [DEPTH_W-1:0] d);
        return (d != '0) ? d - 1'b1 : d;
    endfunction

    assign delim = is_delim(in);

    always_comb begin
        state_nxt = S_JUNK;
        if (delim) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_nxt = is_letter(in, "b") ? S_B1 :
                                     is_letter(in, "e") ? S_E1 : S_JUNK;
                S_B1:    state_nxt = is_letter(in, "e") ? S_B2  : S_JUNK;
                S_B2:    state_nxt = is_letter(in, "g") ? S_B3  : S_JUNK;
                S_B3:    state_nxt = is_letter(in, "i") ? S_B4  : S_JUNK;
                S_B4:    state_nxt = is_letter(in, "n") ? S_BEG : S_JUNK;
                S_E1:    state_nxt = is_letter(in, "n") ? S_E2  : S_JUNK;
                S_E2:    state_nxt = is_letter(in, "d") ? S_END : S_JUNK;
                default: state_nxt = S_JUNK;
            endcase
        end
    end

    // Once an error is latched the counter and flags are frozen until reset.
    always_comb begin
        depth_nxt = depth;
        uf_nxt    = err_underflow;
        of_nxt    = err_overflow;
        if (delim && !err_underflow && !err_overflow) begin
            if (state == S_BEG) begin
                if (depth < MAX_D) depth_nxt = depth_inc(depth);
                else               of_nxt    = 1'b1;
            end else if (state == S_END) begin
                if (depth != '0) depth_nxt = depth_dec(depth);
                else             uf_nxt    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            depth         <= '0;
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
        end else if (in_valid) begin
            state         <= state_nxt;
            depth         <= depth_nxt;
            err_underflow <= uf_nxt;
            err_overflow  <= of_nxt;
        end
    end

    always_comb begin
        pend = '0;
        if (state == S_BEG)      pend = (DEPTH_W+1)'(1);
        else if (state == S_END) pend = -(DEPTH_W+1)'(1);
    end

    assign balance = $signed({1'b0, depth}) + pend;

    assign result = !err_underflow && !err_overflow && (balance == '0) &&
                    !((state == S_END) && (depth == '0));

endmodule
